// File: rtl/bram1be_arb2.sv
// Two-port round-robin arbiter in front of one byte-enable BRAM port.
// Each requester gets an in-order 4-entry response FIFO guarded by issue credits.
module bram1be_arb2 #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 8,
  parameter int WE_WIDTH   = 1,
  parameter int PIPELINED  = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  A_REQ_VALID,
  input  logic                  B_REQ_VALID,
  output logic                  A_REQ_READY,
  output logic                  B_REQ_READY,
  input  logic [WE_WIDTH-1:0]   A_REQ_WE,
  input  logic [WE_WIDTH-1:0]   B_REQ_WE,
  input  logic [ADDR_WIDTH-1:0] A_REQ_ADDR,
  input  logic [ADDR_WIDTH-1:0] B_REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] A_REQ_DI,
  input  logic [DATA_WIDTH-1:0] B_REQ_DI,
  output logic                  A_RSP_VALID,
  output logic                  B_RSP_VALID,
  input  logic                  A_RSP_READY,
  input  logic                  B_RSP_READY,
  output logic [DATA_WIDTH-1:0] A_RSP_DO,
  output logic [DATA_WIDTH-1:0] B_RSP_DO,
  output logic                  BRAM_EN,
  output logic [WE_WIDTH-1:0]   BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  input  logic [DATA_WIDTH-1:0] BRAM_DO
);

  localparam int L     = (PIPELINED != 0) ? 2 : 1;
  localparam int DEPTH = 4;

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  logic [1:0]            req_vld, rsp_rdy, elig, cand, gnt, push, pop;
  logic                  issue, cap_vld, cap_port;
  port_e                 last_q, last_d;
  logic [L-1:0]          sr_vld_q, sr_port_q;
  logic [2:0]            cnt_q    [2];
  logic [2:0]            cnt_d    [2];
  logic [1:0]            wr_ptr_q [2];
  logic [1:0]            wr_ptr_d [2];
  logic [1:0]            rd_ptr_q [2];
  logic [1:0]            rd_ptr_d [2];
  logic [1:0]            infl     [2];
  logic [DATA_WIDTH-1:0] mem_q    [2][DEPTH];

  assign req_vld = {B_REQ_VALID, A_REQ_VALID};
  assign rsp_rdy = {B_RSP_READY, A_RSP_READY};

  // A port may issue only if its FIFO can absorb every response already owed to it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    elig = '0;
    for (int p = 0; p < 2; p++) begin
      infl[p] = '0;
      for (int i = 0; i < L; i++) begin
        if (sr_vld_q[i] && (sr_port_q[i] == 1'(p))) infl[p] = infl[p] + 2'd1;
      end
      elig[p] = ({1'b0, cnt_q[p]} + {2'b00, infl[p]}) < 4'd4;
    end
  end

  assign cand = req_vld & elig;

  always_comb begin
    gnt = 2'b00;
    if (!RST) begin
      case (cand)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_q == PORT_B) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign issue       = |gnt;
  assign A_REQ_READY = gnt[0];
  assign B_REQ_READY = gnt[1];

  assign BRAM_EN   = issue;
  assign BRAM_WE   = gnt[0] ? A_REQ_WE : (gnt[1] ? B_REQ_WE : '0);
  assign BRAM_ADDR = gnt[1] ? B_REQ_ADDR : A_REQ_ADDR;
  assign BRAM_DI   = gnt[1] ? B_REQ_DI   : A_REQ_DI;

  // The oldest in-flight slot lines up with BRAM_DO for that request.
  assign cap_vld  = sr_vld_q[L-1];
  assign cap_port = sr_port_q[L-1];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      push[p]     = cap_vld && (cap_port == 1'(p));
      pop[p]      = (cnt_q[p] != 3'd0) && rsp_rdy[p];
      wr_ptr_d[p] = wr_ptr_q[p] + 2'(push[p]);
      rd_ptr_d[p] = rd_ptr_q[p] + 2'(pop[p]);
      cnt_d[p]    = cnt_q[p] + 3'(push[p]) - 3'(pop[p]);
    end
    last_d = issue ? port_e'(gnt[1]) : last_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sr_vld_q <= '0;
      last_q   <= PORT_B;
      for (int p = 0; p < 2; p++) begin
        cnt_q[p]    <= '0;
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
      end
    end else begin
      sr_vld_q[0] <= issue;
      for (int i = 1; i < L; i++) sr_vld_q[i] <= sr_vld_q[i-1];
      last_q <= last_d;
      for (int p = 0; p < 2; p++) begin
        cnt_q[p]    <= cnt_d[p];
        wr_ptr_q[p] <= wr_ptr_d[p];
        rd_ptr_q[p] <= rd_ptr_d[p];
      end
    end
  end

  // NOTE: payload storage is not reset; the valid bits and counters alone decide what is live.
  always_ff @(posedge CLK) begin
    sr_port_q[0] <= gnt[1];
    for (int i = 1; i < L; i++) sr_port_q[i] <= sr_port_q[i-1];
    for (int p = 0; p < 2; p++) begin
      if (push[p]) mem_q[p][wr_ptr_q[p]] <= BRAM_DO;
    end
  end

  assign A_RSP_VALID = cnt_q[0] != 3'd0;
  assign B_RSP_VALID = cnt_q[1] != 3'd0;
  assign A_RSP_DO    = mem_q[0][rd_ptr_q[0]];
  assign B_RSP_DO    = mem_q[1][rd_ptr_q[1]];

endmodule

// File: tb/tb_bram1be_arb2.sv
// Drives one request stream into a 1-cycle and a 2-cycle BRAM arbiter side by side;
// a reference memory computes each expected response when the request is accepted.
module tb_bram1be_arb2;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int WW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          a_vld, b_vld, a_rrdy, b_rrdy;
  logic [WW-1:0] a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_di, b_di;

  logic          a_rdy0, b_rdy0, a_rv0, b_rv0, en0;
  logic [DW-1:0] a_do0, b_do0, di0, do0;
  logic [WW-1:0] we0;
  logic [AW-1:0] addr0;

  logic          a_rdy1, b_rdy1, a_rv1, b_rv1, en1;
  logic [DW-1:0] a_do1, b_do1, di1, do1, do1_p;
  logic [WW-1:0] we1;
  logic [AW-1:0] addr1;

  logic [DW-1:0] mem0 [16];
  logic [DW-1:0] mem1 [16];
  logic [DW-1:0] ref0 [16];
  logic [DW-1:0] ref1 [16];
  logic [DW-1:0] q0a [$];
  logic [DW-1:0] q0b [$];
  logic [DW-1:0] q1a [$];
  logic [DW-1:0] q1b [$];
  logic [DW-1:0] mon_w;

  int tests = 0;
  int fails = 0;

  bram1be_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW), .PIPELINED(0)) dut0 (
    .CLK(clk), .RST(rst),
    .A_REQ_VALID(a_vld), .B_REQ_VALID(b_vld), .A_REQ_READY(a_rdy0), .B_REQ_READY(b_rdy0),
    .A_REQ_WE(a_we), .B_REQ_WE(b_we), .A_REQ_ADDR(a_addr), .B_REQ_ADDR(b_addr),
    .A_REQ_DI(a_di), .B_REQ_DI(b_di), .A_RSP_VALID(a_rv0), .B_RSP_VALID(b_rv0),
    .A_RSP_READY(a_rrdy), .B_RSP_READY(b_rrdy), .A_RSP_DO(a_do0), .B_RSP_DO(b_do0),
    .BRAM_EN(en0), .BRAM_WE(we0), .BRAM_ADDR(addr0), .BRAM_DI(di0), .BRAM_DO(do0)
  );

  bram1be_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW), .PIPELINED(1)) dut1 (
    .CLK(clk), .RST(rst),
    .A_REQ_VALID(a_vld), .B_REQ_VALID(b_vld), .A_REQ_READY(a_rdy1), .B_REQ_READY(b_rdy1),
    .A_REQ_WE(a_we), .B_REQ_WE(b_we), .A_REQ_ADDR(a_addr), .B_REQ_ADDR(b_addr),
    .A_REQ_DI(a_di), .B_REQ_DI(b_di), .A_RSP_VALID(a_rv1), .B_RSP_VALID(b_rv1),
    .A_RSP_READY(a_rrdy), .B_RSP_READY(b_rrdy), .A_RSP_DO(a_do1), .B_RSP_DO(b_do1),
    .BRAM_EN(en1), .BRAM_WE(we1), .BRAM_ADDR(addr1), .BRAM_DI(di1), .BRAM_DO(do1)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [WW-1:0] we,
                                          input logic [DW-1:0] di);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < WW; i++) if (we[i]) r[8*i +: 8] = di[8*i +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 5) return 32'h0000_00AB;
    if (i == 3) return 32'hAABB_CCDD;
    return 32'h1234_0000 + 32'(i) * 32'h0000_0111;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write-through BRAMs: 1-cycle read for dut0, extra output register for dut1.
  always @(posedge clk) begin
    if (en0) begin
      mem0[addr0] <= merge(mem0[addr0], we0, di0);
      do0         <= merge(mem0[addr0], we0, di0);
    end
    if (en1) begin
      mem1[addr1] <= merge(mem1[addr1], we1, di1);
      do1_p       <= merge(mem1[addr1], we1, di1);
    end
    do1 <= do1_p;
  end

  // Scoreboard: push at request handshake, pop at response handshake.
  always @(negedge clk) begin
    if (rst) begin
      check("reset_ready_en_low", 32'({a_rdy0, b_rdy0, a_rdy1, b_rdy1, en0, en1}), 32'd0);
      q0a.delete(); q0b.delete(); q1a.delete(); q1b.delete();
    end else begin
      check("dut0_ready_exclusive", 32'(a_rdy0 & b_rdy0), 32'd0);
      check("dut1_ready_exclusive", 32'(a_rdy1 & b_rdy1), 32'd0);
      if (a_vld && a_rdy0) begin
        mon_w = merge(ref0[a_addr], a_we, a_di); ref0[a_addr] = mon_w; q0a.push_back(mon_w);
      end
      if (b_vld && b_rdy0) begin
        mon_w = merge(ref0[b_addr], b_we, b_di); ref0[b_addr] = mon_w; q0b.push_back(mon_w);
      end
      if (a_vld && a_rdy1) begin
        mon_w = merge(ref1[a_addr], a_we, a_di); ref1[a_addr] = mon_w; q1a.push_back(mon_w);
      end
      if (b_vld && b_rdy1) begin
        mon_w = merge(ref1[b_addr], b_we, b_di); ref1[b_addr] = mon_w; q1b.push_back(mon_w);
      end
      if (a_rv0 && a_rrdy) begin
        check("dut0_a_rsp_expected", 32'(q0a.size() != 0), 32'd1);
        if (q0a.size() != 0) check("dut0_a_rsp_data", a_do0, q0a.pop_front());
      end
      if (b_rv0 && b_rrdy) begin
        check("dut0_b_rsp_expected", 32'(q0b.size() != 0), 32'd1);
        if (q0b.size() != 0) check("dut0_b_rsp_data", b_do0, q0b.pop_front());
      end
      if (a_rv1 && a_rrdy) begin
        check("dut1_a_rsp_expected", 32'(q1a.size() != 0), 32'd1);
        if (q1a.size() != 0) check("dut1_a_rsp_data", a_do1, q1a.pop_front());
      end
      if (b_rv1 && b_rrdy) begin
        check("dut1_b_rsp_expected", 32'(q1b.size() != 0), 32'd1);
        if (q1b.size() != 0) check("dut1_b_rsp_data", b_do1, q1b.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  acc0, acc1, ia, ib;
    logic hsa, hsb;
    for (int i = 0; i < 16; i++) begin
      mem0[i] <= init_word(i);
      mem1[i] <= init_word(i);
      ref0[i] = init_word(i);
      ref1[i] = init_word(i);
    end
    // Reset with both requesters already asking: nothing may be granted.
    rst = 1'b1; a_vld = 1'b1; b_vld = 1'b1; a_we = '0; b_we = '0;
    a_addr = '0; b_addr = '0; a_di = '0; b_di = '0; a_rrdy = 1'b1; b_rrdy = 1'b1;
    repeat (3) step();
    rst = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
    #1;
    check("post_reset_rsp_valid", 32'({a_rv0, b_rv0, a_rv1, b_rv1}), 32'd0);

    // Single read of preloaded 0xAB: issue at t, response at t+2 (t+3 when pipelined).
    step(); a_vld = 1'b1; a_addr = 4'd5; a_we = '0;
    #1;
    check("rd_t_a_ready", 32'(a_rdy0), 32'd1);
    check("rd_t_bram_en", 32'({en0, en1}), 32'b11);
    check("rd_t_bram_addr", 32'(addr0), 32'd5);
    check("rd_t_bram_we", 32'(we0), 32'd0);
    step(); a_vld = 1'b0;
    #1 check("rd_t1_rsp_not_yet", 32'(a_rv0), 32'd0);
    step();
    #1;
    check("rd_t2_rsp_valid", 32'(a_rv0), 32'd1);
    check("rd_t2_rsp_data", a_do0, 32'h0000_00AB);
    check("rd_t2_pipe_not_yet", 32'(a_rv1), 32'd0);
    step();
    #1;
    check("rd_t3_pipe_rsp_valid", 32'(a_rv1), 32'd1);
    check("rd_t3_pipe_rsp_data", a_do1, 32'h0000_00AB);
    check("rd_t3_rsp_popped", 32'(a_rv0), 32'd0);

    // Partial byte-enable write from B, then read it back from A.
    step(); b_vld = 1'b1; b_addr = 4'd3; b_we = 4'b0101; b_di = 32'h1122_3344;
    #1;
    check("wr_b_ready", 32'(b_rdy0), 32'd1);
    check("wr_bram_we", 32'(we0), 32'b0101);
    check("wr_bram_di", di0, 32'h1122_3344);
    step(); b_vld = 1'b0; b_we = '0;
    step();
    #1 check("wr_b_rsp_data", b_do0, 32'hAA22_CC44);
    step();
    #1 check("wr_b_pipe_rsp_data", b_do1, 32'hAA22_CC44);
    step(); a_vld = 1'b1; a_addr = 4'd3; a_we = '0;
    step(); a_vld = 1'b0;
    step();
    #1 check("rdback_a_data", a_do0, 32'hAA22_CC44);
    step();
    #1 check("rdback_a_pipe_data", a_do1, 32'hAA22_CC44);

    // A backpressured: only four A requests may be outstanding while B keeps flowing.
    step(); a_rrdy = 1'b0; a_vld = 1'b1; a_addr = 4'd5; b_vld = 1'b1; b_addr = 4'd7; b_we = '0;
    acc0 = 0; acc1 = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (a_vld && a_rdy0) acc0++;
      if (a_vld && a_rdy1) acc1++;
      step();
    end
    #1;
    check("bp_a_accepts_dut0", 32'(acc0), 32'd4);
    check("bp_a_accepts_dut1", 32'(acc1), 32'd4);
    check("bp_a_blocked", 32'({a_rdy0, a_rdy1}), 32'b00);
    check("bp_b_granted", 32'({b_rdy0, b_rdy1}), 32'b11);
    check("bp_a_rsp_held", 32'({a_rv0, a_rv1}), 32'b11);
    step(); a_rrdy = 1'b1;
    step();
    #1 check("bp_a_resumes", 32'({a_rdy0, a_rdy1}), 32'b11);
    step(); a_vld = 1'b0; b_vld = 1'b0;
    repeat (10) step();

    // Reset while A and B reads are both in flight in the pipelined instance.
    a_vld = 1'b1; a_addr = 4'd1; a_we = '0;
    step(); a_vld = 1'b0; b_vld = 1'b1; b_addr = 4'd2; b_we = '0;
    step(); b_vld = 1'b0; rst = 1'b1;
    step(); rst = 1'b0;
    #1 check("mid_reset_rsp_cleared", 32'({a_rv0, b_rv0, a_rv1, b_rv1}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      #1 check("mid_reset_no_late_rsp", 32'({a_rv0, b_rv0, a_rv1, b_rv1}), 32'd0);
    end

    // Both ports request every cycle: grants alternate starting with A.
    step();
    ia = 0; ib = 0;
    a_vld = 1'b1; a_addr = 4'(8 + ia); a_we = ia[0] ? 4'hF : 4'h0; a_di = 32'hA0A0_0000 + 32'(ia);
    b_vld = 1'b1; b_addr = 4'(10 + ib); b_we = (ib % 3 == 0) ? 4'b0011 : 4'b0000;
    b_di = 32'h0B0B_0000 + 32'(ib) * 32'h0000_1001;
    for (int c = 0; c < 12; c++) begin
      #1;
      check("rr_a_grant_dut0", 32'(a_rdy0), 32'(c % 2 == 0));
      check("rr_b_grant_dut0", 32'(b_rdy0), 32'(c % 2 == 1));
      check("rr_grant_dut1", 32'({a_rdy1, b_rdy1}), 32'({a_rdy0, b_rdy0}));
      hsa = a_rdy0; hsb = b_rdy0;
      step();
      if (hsa) begin
        ia++;
        a_addr = 4'(8 + ia); a_we = ia[0] ? 4'hF : 4'h0; a_di = 32'hA0A0_0000 + 32'(ia);
      end
      if (hsb) begin
        ib++;
        b_addr = 4'(10 + ib); b_we = (ib % 3 == 0) ? 4'b0011 : 4'b0000;
        b_di = 32'h0B0B_0000 + 32'(ib) * 32'h0000_1001;
      end
    end
    a_vld = 1'b0; b_vld = 1'b0;
    repeat (8) step();

    check("drain_dut0_a", 32'(q0a.size()), 32'd0);
    check("drain_dut0_b", 32'(q0b.size()), 32'd0);
    check("drain_dut1_a", 32'(q1a.size()), 32'd0);
    check("drain_dut1_b", 32'(q1b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bram1be_arb2.md
BRAM1BE_ARB2 -- requirements
Module: bram1be_arb2

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 1, meaning the BRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the data word width.
REQ-003 SHALL have parameter WE_WIDTH, default 1, meaning the number of byte-enable lanes; DATA_WIDTH = 8*WE_WIDTH.
REQ-004 SHALL have parameter PIPELINED, default 0, meaning BRAM read latency is 1 cycle when 0 and 2 cycles when 1.
REQ-005 SHALL have ports, in this order:
- CLK  in  1  single clock, all state updated on posedge.
- RST  in  1  reset, synchronous, active-high.
- A_REQ_VALID / B_REQ_VALID  in  1  request valid, per port.
- A_REQ_READY / B_REQ_READY  out  1  request accepted this cycle.
- A_REQ_WE / B_REQ_WE  in  WE_WIDTH  byte enables; all-zero means read.
- A_REQ_ADDR / B_REQ_ADDR  in  ADDR_WIDTH  word address.
- A_REQ_DI / B_REQ_DI  in  DATA_WIDTH  write data.
- A_RSP_VALID / B_RSP_VALID  out  1  response valid.
- A_RSP_READY / B_RSP_READY  in  1  response consumed.
- A_RSP_DO / B_RSP_DO  out  DATA_WIDTH  response data.
- BRAM_EN  out  1  BRAM enable.
- BRAM_WE  out  WE_WIDTH  BRAM byte enables.
- BRAM_ADDR  out  ADDR_WIDTH  BRAM address.
- BRAM_DI  out  DATA_WIDTH  BRAM write data.
- BRAM_DO  in  DATA_WIDTH  BRAM read data.

Function
REQ-006 SHALL issue at most one request per cycle to the BRAM.
REQ-007 SHALL accept a request (handshake) when REQ_VALID and REQ_READY are both high in the same cycle; REQ_READY SHALL be combinational from grant and never high for both ports in one cycle.
REQ-008 SHALL drive BRAM_EN=1 and the granted port's WE/ADDR/DI combinationally in the handshake cycle; otherwise BRAM_EN=0 and BRAM_WE=0.
REQ-009 SHALL return exactly one response per accepted request, reads and writes alike; a write response carries BRAM_DO (write-through data, unwritten lanes hold old contents).
REQ-010 SHALL give each port a 4-entry response FIFO; responses per port in acceptance order.
REQ-011 SHALL capture BRAM_DO into the owning port's FIFO exactly L cycles after issue, L = PIPELINED ? 2 : 1, using an L-deep in-flight shift register of {valid, port id}.
REQ-012 SHALL be eligible to grant a port only when its FIFO occupancy plus its in-flight count is less than 4 (credit check); no FIFO overflow is possible.
REQ-013 SHALL arbitrate round-robin: when both are valid and eligible, grant the port not granted most recently; when one is eligible, grant it; the last-grant pointer updates only on handshake.
REQ-014 SHALL present the FIFO head on RSP_DO with RSP_VALID=1 when non-empty; pop on RSP_VALID&&RSP_READY.
REQ-015 SHALL handle a capture and a pop on the same FIFO in the same cycle with occupancy unchanged, including when full or empty+bypass is not used (capture into empty FIFO becomes visible the next cycle).
REQ-016 SHALL sustain one issue per cycle when the response side is always ready (throughput 1/cycle total).
REQ-017 SHALL maintain FIFO pointers modulo 4 and occupancy 0..4 in 3 bits.

Reset
REQ-018 SHALL, while RST=1 at posedge, clear FIFOs (RSP_VALID=0), clear the in-flight register, and set the last-grant pointer to B so A wins the first conflict.
REQ-019 SHALL force A_REQ_READY=B_REQ_READY=0 and BRAM_EN=0 in any cycle with RST=1.
REQ-020 SHALL discard BRAM_DO for requests issued before a reset; no response for them appears after reset.

Verification
REQ-021 PIPELINED=0: A reads addr 5 (preloaded 0xAB) at cycle t -> BRAM_EN=1 at t; A_RSP_VALID=1, A_RSP_DO=0xAB at t+2.
REQ-022 Both ports valid every cycle after reset, rsp ready high -> grants A,B,A,B...; each port gets its responses in order.
REQ-023 WE_WIDTH=4: B writes 0x11223344 with WE=4'b0101 over 0xAABBCCDD -> B response 0xAA22CC44; later read returns 0xAA22CC44.
REQ-024 A_RSP_READY=0, A valid continuously, PIPELINED=1 -> exactly 4 A requests accepted, then A_REQ_READY=0 while B still granted; raising A_RSP_READY resumes A.
REQ-025 Assert RST one cycle while 2 requests in flight -> next cycle all RSP_VALID=0, no late responses; first post-reset conflict granted to A.
